fader_envelope: RTL and testbench
=================================

// Module: fader_envelope
// PURPOSE
//  Parametrised fade-envelope generator and gain stage for the audio effects path.
//  Produces a saturating linear gain ramp (out, hold, in, or out-and-park) advanced once per accepted sample.
//  Applies that gain to the incoming signed sample stream; sits between the effect mux and the output codec.
// PARAMETERS
//  SAMPLE_W  16  signed sample width
//  GAIN_W    16  unsigned gain width; all-ones = unity
//  HOLD_W    22  hold-length counter width (samples)
// PORTS
//  clk           in   1         system clock
//  reset         in   1         synchronous, active-high reset
//  start         in   1         pulse: begin fade (IDLE) / resume from MUTED
//  abort         in   1         pulse: return to IDLE, unity gain
//  mode          in   2         00 out-hold-in, 01 out-and-park, 10 in-only, 11 = 00
//  rate          in   GAIN_W    gain delta per sample; 0 treated as 1
//  hold_len      in   HOLD_W    samples held at gain 0 (mode 00)
//  sample_valid  in   1         sample_in strobe; ramp advances only on it
//  sample_in     in   SAMPLE_W  signed input sample
//  sample_out    out  SAMPLE_W  scaled sample, registered
//  out_valid     out  1         sample_out valid, 1 cycle after sample_valid
//  gain          out  GAIN_W    current gain
//  busy          out  1         state != IDLE
//  done          out  1         1-cycle pulse on UP->IDLE completion
// BEHAVIOUR
//  Reset: state IDLE, gain all-ones, sample_out 0, out_valid 0, busy 0, done 0, hold_cnt 0.
//  mode, rate, hold_len latched when start is accepted; later changes ignored until next start.
//  States:
//   IDLE: start -> DOWN (mode 00/01/11), or UP with gain loaded 0 (mode 10).
//   DOWN: on valid, gain = max(gain-rate, 0); at 0 ->
//     MUTED (mode 01), UP (hold_len==0), else HOLD with hold_cnt = hold_len.
//   HOLD: on valid, hold_cnt--; at hold_cnt==1 -> UP, so exactly hold_len samples at gain 0.
//   MUTED: gain 0 indefinitely; start -> UP.
//   UP: on valid, gain = min(gain+rate, all-ones); reaching all-ones -> IDLE, done=1 next cycle.
//  Saturating arithmetic: compute in GAIN_W+1 bits and clamp; no wrap-around ever.
//  start while busy: ignored, except in MUTED.
//  abort: any state -> IDLE next cycle; gain all-ones, no done; abort wins over simultaneous start.
//  Datapath:
//   - Latency 1: out_valid = registered sample_valid.
//   - Scaling uses gain value before that sample's ramp update.
//   - IDLE: sample_out = sample_in exactly (bypass).
//   - Other states: sample_out = (signed sample_in * {1'b0,gain}) >>> GAIN_W,
//     arithmetic shift, truncated toward -inf.
//   - abort/reset mid-stream: pending out_valid still issues; reset clears it.
// CONFIGURATION
//  FADER_ENVELOPE_STEREO_EN defined:
//   - adds ports sample_in_r (in, SAMPLE_W) and sample_out_r (out, SAMPLE_W).
//   - right channel uses the same gain, sample_valid and out_valid; identical latency and bypass.
//   - sample_out_r resets to 0.
//  Undefined: mono only; no _r ports exist.
// TESTING  (defaults SAMPLE_W=16, GAIN_W=16)
//  1 Reset, then IDLE valid sample_in=0x1234 -> next cycle out_valid=1, sample_out=0x1234;
//    gain=0xFFFF, busy=0.
//  2 mode 00, rate 0x4000, hold_len 2, start, continuous valids:
//    gain FFFF,BFFF,7FFF,3FFF,0000; 2 samples held at 0; then 4000,8000,C000,FFFF;
//    done pulses once, busy drops.
//  3 Forced gain 0x8000 in HOLD-free ramp: sample 0x4000 -> 0x2000; sample 0x8000 -> 0xC000;
//    sample 0xFFFF -> 0xFFFF (floor).
//  4 mode 01, rate 0xFFFF: one valid -> gain 0, MUTED; 100 valids give sample_out 0;
//    start -> UP, one valid -> FFFF, done.
//  5 mode 00 mid-DOWN, abort+start same cycle -> next cycle IDLE, gain FFFF, busy 0, no done;
//    rate 0 in mode 10 steps gain 0,1,2.
//  6 STEREO_EN build: L=0x4000, R=0xC000 at gain 0x8000 -> 0x2000 / 0xE000 same cycle.

Source files
------------

// File: rtl/fader_envelope.sv
// fader_envelope: saturating linear fade-envelope generator and gain stage.
// Ramps a gain (out-hold-in, out-and-park, in-only) once per accepted sample
// and scales the signed sample stream by it; bypasses samples when idle.
// Ports:
//   clk, reset (sync, active-high)
//   start, abort          fade control pulses
//   mode, rate, hold_len  fade shape, latched when a fade starts
//   sample_valid, sample_in      input stream
//   sample_out, out_valid        scaled stream, one cycle latency
//   gain, busy, done             envelope status
// Build option FADER_ENVELOPE_STEREO_EN adds sample_in_r / sample_out_r,
// a right channel sharing gain, strobes and latency with the left channel.
module fader_envelope #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 16,
    parameter int HOLD_W   = 22
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [GAIN_W-1:0]   rate,
    input  logic [HOLD_W-1:0]   hold_len,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
`ifdef FADER_ENVELOPE_STEREO_EN
    input  logic [SAMPLE_W-1:0] sample_in_r,
    output logic [SAMPLE_W-1:0] sample_out_r,
`endif
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_valid,
    output logic [GAIN_W-1:0]   gain,
    output logic                busy,
    output logic                done
);

    localparam int PW = SAMPLE_W + GAIN_W;
    localparam logic [GAIN_W-1:0] G_MAX = '1;

    typedef enum logic [2:0] {IDLE, DOWN, HOLD, MUTED, UP} state_t;

    state_t            state, state_n;
    logic [GAIN_W-1:0] gain_q, gain_n;
    logic [GAIN_W-1:0] rate_q, rate_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              park_q, park_n;
    logic              done_n;

    // One extra bit exposes borrow / carry so the ramp clamps, never wraps.
    logic [GAIN_W:0]   diff, sum;
    logic [GAIN_W-1:0] gain_dn, gain_up;

    assign diff    = {1'b0, gain_q} - {1'b0, rate_q};
    assign sum     = {1'b0, gain_q} + {1'b0, rate_q};
    assign gain_dn = diff[GAIN_W] ? '0 : diff[GAIN_W-1:0];
    assign gain_up = sum[GAIN_W] ? G_MAX : sum[GAIN_W-1:0];

    always_comb begin
        state_n    = state;
        gain_n     = gain_q;
        rate_n     = rate_q;
        hold_n     = hold_q;
        hold_cnt_n = hold_cnt;
        park_n     = park_q;
        done_n     = 1'b0;
        if (abort) begin
            state_n = IDLE;
            gain_n  = G_MAX;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rate_n = (rate == '0) ? GAIN_W'(1) : rate;
                        hold_n = hold_len;
                        park_n = (mode == 2'b01);
                        if (mode == 2'b10) begin
                            state_n = UP;
                            gain_n  = '0;
                        end else begin
                            state_n = DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (sample_valid) begin
                        gain_n = gain_dn;
                        if (gain_dn == '0) begin
                            if (park_q) begin
                                state_n = MUTED;
                            end else if (hold_q == '0) begin
                                state_n = UP;
                            end else begin
                                state_n    = HOLD;
                                hold_cnt_n = hold_q;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (sample_valid) begin
                        hold_cnt_n = hold_cnt - HOLD_W'(1);
                        if (hold_cnt == HOLD_W'(1)) begin
                            state_n = UP;
                        end
                    end
                end
                MUTED: begin
                    if (start) begin
                        state_n = UP;
                    end
                end
                UP: begin
                    if (sample_valid) begin
                        gain_n = gain_up;
                        if (gain_up == G_MAX) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gain_q   <= G_MAX;
            rate_q   <= GAIN_W'(1);
            hold_q   <= '0;
            hold_cnt <= '0;
            park_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            gain_q   <= gain_n;
            rate_q   <= rate_n;
            hold_q   <= hold_n;
            hold_cnt <= hold_cnt_n;
            park_q   <= park_n;
            done     <= done_n;
        end
    end

    // Sign-extended sample times zero-extended gain; the shift floors.
    logic signed [PW-1:0]       prod_l;
    logic        [SAMPLE_W-1:0] scaled_l;

    assign prod_l   = $signed({{GAIN_W{sample_in[SAMPLE_W-1]}}, sample_in})
                    * $signed({{SAMPLE_W{1'b0}}, gain_q});
    assign scaled_l = SAMPLE_W'(prod_l >>> GAIN_W);

`ifdef FADER_ENVELOPE_STEREO_EN
    logic signed [PW-1:0]       prod_r;
    logic        [SAMPLE_W-1:0] scaled_r;

    assign prod_r   = $signed({{GAIN_W{sample_in_r[SAMPLE_W-1]}}, sample_in_r})
                    * $signed({{SAMPLE_W{1'b0}}, gain_q});
    assign scaled_r = SAMPLE_W'(prod_r >>> GAIN_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_r <= '0;
        end else if (sample_valid) begin
            sample_out_r <= (state == IDLE) ? sample_in_r : scaled_r;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= sample_valid;
            if (sample_valid) begin
                sample_out <= (state == IDLE) ? sample_in : scaled_l;
            end
        end
    end

    assign gain = gain_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fader_envelope.sv
// tb_fader_envelope: directed and randomized checks of fader_envelope.
// The reference model expands each fade into the list of per-sample gains.
module tb_fader_envelope;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] rate = 16'h0;
    logic [21:0] hold_len = 22'h0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic [15:0] sample_out;
    logic        out_valid;
    logic [15:0] gain;
    logic        busy;
    logic        done;
    logic [15:0] sample_in_r = 16'h0;
`ifdef FADER_ENVELOPE_STEREO_EN
    logic [15:0] sample_out_r;
`endif

    fader_envelope #(.SAMPLE_W(16), .GAIN_W(16), .HOLD_W(22)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .mode(mode),
        .rate(rate),
        .hold_len(hold_len),
        .sample_valid(sample_valid),
        .sample_in(sample_in),
`ifdef FADER_ENVELOPE_STEREO_EN
        .sample_in_r(sample_in_r),
        .sample_out_r(sample_out_r),
`endif
        .sample_out(sample_out),
        .out_valid(out_valid),
        .gain(gain),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: queue of gains still to be applied, one per sample.
    int          q[$];
    bit          parked;
    bit          park_after;
    int          lat_rate;
    logic [15:0] exp_out;
    logic [15:0] exp_out_r;
    bit          exp_ov;
    bit          exp_done;

    function automatic logic [15:0] scale(logic [15:0] s, int g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
        p = p >>> 16;
        return p[15:0];
    endfunction

    function automatic void build_up(int r);
        int g;
        g = 0;
        while (g != 65535) begin
            q.push_back(g);
            g = (g + r > 65535) ? 65535 : g + r;
        end
    endfunction

    function automatic void build_down(int r, int h, bit park);
        int g;
        g = 65535;
        while (g != 0) begin
            q.push_back(g);
            g = (g > r) ? g - r : 0;
        end
        if (park) begin
            park_after = 1'b1;
        end else begin
            repeat (h) q.push_back(0);
            build_up(r);
        end
    endfunction

    function automatic int exp_gain();
        if (q.size() > 0) return q[0];
        if (parked) return 0;
        return 65535;
    endfunction

    function automatic void model_step();
        bit idle_pre;
        bit park_pre;
        int g;
        if (reset) begin
            q.delete();
            parked = 0; park_after = 0;
            exp_ov = 0; exp_done = 0;
            exp_out = 0; exp_out_r = 0;
            return;
        end
        idle_pre = (q.size() == 0) && !parked;
        park_pre = parked;
        exp_ov = sample_valid;
        exp_done = 0;
        if (sample_valid) begin
            if (idle_pre) begin
                exp_out = sample_in;
                exp_out_r = sample_in_r;
            end else begin
                g = exp_gain();
                exp_out = scale(sample_in, g);
                exp_out_r = scale(sample_in_r, g);
                if (!parked) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        if (park_after) begin
                            parked = 1; park_after = 0;
                        end else begin
                            exp_done = 1;
                        end
                    end
                end
            end
        end
        if (abort) begin
            q.delete();
            parked = 0; park_after = 0; exp_done = 0;
        end else if (start) begin
            if (idle_pre) begin
                lat_rate = (rate == 0) ? 1 : int'(rate);
                case (mode)
                    2'b10: build_up(lat_rate);
                    2'b01: build_down(lat_rate, 0, 1'b1);
                    default: build_down(lat_rate, int'(hold_len), 1'b0);
                endcase
            end else if (park_pre) begin
                parked = 0;
                build_up(lat_rate);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        start = 1'b0;
        abort = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_valid = 1'b1;
        sample_in = 16'h5555;
        tick();
        tick();
        reset = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ov got %b want 0", out_valid);
        end
        n_chk++;
        if (sample_out !== 16'h0) begin
            n_fail++; $display("FAIL reset_out got %h want 0000", sample_out);
        end
        n_chk++;
        if (gain !== 16'hFFFF || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got gain=%h busy=%b done=%b want ffff/0/0",
                     gain, busy, done);
        end
    endtask

    task automatic test_bypass();
        sample_valid = 1'b1;
        sample_in = 16'h1234;
        sample_in_r = 16'hBEEF;
        tick();
        n_chk++;
        if (out_valid !== 1'b1 || sample_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL bypass got ov=%b out=%h want 1/1234", out_valid, sample_out);
        end
`ifdef FADER_ENVELOPE_STEREO_EN
        n_chk++;
        if (sample_out_r !== 16'hBEEF) begin
            n_fail++; $display("FAIL bypass_r got %h want beef", sample_out_r);
        end
`endif
        n_chk++;
        if (gain !== 16'hFFFF || busy !== 1'b0) begin
            n_fail++; $display("FAIL bypass_status got %h/%b want ffff/0", gain, busy);
        end
        tick();
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bypass_ov_drop got %b want 0", out_valid);
        end
    endtask

    task automatic test_fade_hold();
        logic [15:0] exp_g[10] = '{16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000, 16'h0000,
                                   16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        mode = 2'b00; rate = 16'h4000; hold_len = 22'd2;
        start = 1'b1;
        tick();
        mode = 2'b10; rate = 16'h0001; hold_len = 22'd9;
        n_chk++;
        if (gain !== 16'hFFFF || busy !== 1'b1) begin
            n_fail++; $display("FAIL fade_start got %h/%b want ffff/1", gain, busy);
        end
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'h7FFF;
            tick();
            n_chk++;
            if (gain !== exp_g[i] || done !== (i == 9)) begin
                n_fail++;
                $display("FAIL fade_step%0d got gain=%h done=%b want %h/%b",
                         i, gain, done, exp_g[i], (i == 9));
            end
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL fade_busy got %b want 0", busy);
        end
        tick();
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL fade_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_scaling();
        logic [15:0] sl[3] = '{16'h4000, 16'h8000, 16'hFFFF};
        logic [15:0] el[3] = '{16'h2000, 16'hC000, 16'hFFFF};
        logic [15:0] sr[3] = '{16'hC000, 16'h4000, 16'h8000};
        logic [15:0] er[3] = '{16'hE000, 16'h2000, 16'hC000};
        for (int i = 0; i < 3; i++) begin
            mode = 2'b10; rate = 16'h8000;
            start = 1'b1;
            tick();
            sample_valid = 1'b1;
            tick();
            n_chk++;
            if (gain !== 16'h8000) begin
                n_fail++; $display("FAIL scale_gain%0d got %h want 8000", i, gain);
            end
            sample_valid = 1'b1;
            sample_in = sl[i];
            sample_in_r = sr[i];
            tick();
            n_chk++;
            if (sample_out !== el[i]) begin
                n_fail++;
                $display("FAIL scale%0d got %h want %h", i, sample_out, el[i]);
            end
`ifdef FADER_ENVELOPE_STEREO_EN
            n_chk++;
            if (sample_out_r !== er[i]) begin
                n_fail++;
                $display("FAIL scale_r%0d got %h want %h", i, sample_out_r, er[i]);
            end
`else
            if (er[i] == sr[i]) $display("note: unexpected table entry");
`endif
        end
    endtask

    task automatic test_park();
        int bad;
        mode = 2'b01; rate = 16'hFFFF;
        start = 1'b1;
        tick();
        sample_valid = 1'b1;
        tick();
        n_chk++;
        if (gain !== 16'h0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL park_enter got %h/%b want 0000/1", gain, busy);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'($urandom);
            tick();
            if (sample_out !== 16'h0 || gain !== 16'h0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL park_mute got %0d bad samples want 0", bad);
        end
        start = 1'b1;
        tick();
        sample_valid = 1'b1;
        tick();
        n_chk++;
        if (gain !== 16'hFFFF || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL park_resume got gain=%h done=%b busy=%b want ffff/1/0",
                     gain, done, busy);
        end
    endtask

    task automatic test_abort();
        mode = 2'b00; rate = 16'h1000; hold_len = 22'd3;
        start = 1'b1;
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b1;
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        n_chk++;
        if (gain !== 16'hFFFF || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort got gain=%h busy=%b done=%b want ffff/0/0",
                     gain, busy, done);
        end
        mode = 2'b10; rate = 16'h0000;
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (gain !== 16'(i)) begin
                n_fail++; $display("FAIL rate0_step%0d got %h want %0d", i, gain, i);
            end
            sample_valid = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int bad_ov, bad_out, bad_st;
        bad_ov = 0; bad_out = 0; bad_st = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 1500);
            start = ($urandom_range(0, 99) < 8);
            abort = ($urandom_range(0, 299) == 0);
            sample_valid = ($urandom_range(0, 9) < 7);
            mode = 2'($urandom);
            rate = 16'($urandom_range(16'h0800, 16'hFFFF));
            hold_len = 22'($urandom_range(0, 4));
            sample_in = 16'($urandom);
            sample_in_r = 16'($urandom);
            tick();
            n_chk++;
            if (out_valid !== exp_ov) begin
                bad_ov++; n_fail++;
                if (bad_ov < 5) $display("FAIL rand_ov cyc%0d got %b want %b", i, out_valid, exp_ov);
            end
            if (exp_ov) begin
                n_chk++;
                if (sample_out !== exp_out) begin
                    bad_out++; n_fail++;
                    if (bad_out < 5) $display("FAIL rand_out cyc%0d got %h want %h", i, sample_out, exp_out);
                end
`ifdef FADER_ENVELOPE_STEREO_EN
                n_chk++;
                if (sample_out_r !== exp_out_r) begin
                    bad_out++; n_fail++;
                    if (bad_out < 5) $display("FAIL rand_out_r cyc%0d got %h want %h", i, sample_out_r, exp_out_r);
                end
`endif
            end
            n_chk++;
            if (gain !== 16'(exp_gain()) || busy !== (q.size() > 0 || parked) || done !== exp_done) begin
                bad_st++; n_fail++;
                if (bad_st < 5)
                    $display("FAIL rand_status cyc%0d got gain=%h busy=%b done=%b want %h/%b/%b",
                             i, gain, busy, done, 16'(exp_gain()), (q.size() > 0 || parked), exp_done);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_bypass();
        test_fade_hold();
        test_scaling();
        test_park();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
